hqm_aw_rmw_req_fifo_issue: RTL and testbench

Request buffer and issue stage directly upstream of the 4-stage read-modify-write memory pipeline. It accepts RMW commands over a valid/ready handshake and holds them in a small circular FIFO. It presents the head entry on the pipeline's p0 next-state inputs whenever the pipeline's p0 stage is not held. It also keeps occupancy and high-water-mark status for the owning unit's config/status space.

---
 rtl/hqm_aw_rmw_req_fifo_issue_if.sv | 44 ++++
 rtl/hqm_aw_rmw_req_fifo_issue.sv | 88 ++++++++
 tb/tb_hqm_aw_rmw_req_fifo_issue.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/hqm_aw_rmw_req_fifo_issue_if.sv
// +----------------------------------------------------------------------------+
// | hqm_aw_rmw_req_fifo_issue_if : RMW command type and request/issue bundle   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package hqm_aw_rmwpipe_pkg;
    typedef enum logic [1:0] {
        HQM_AW_RMWPIPE_NOOP  = 2'd0,
        HQM_AW_RMWPIPE_READ  = 2'd1,
        HQM_AW_RMWPIPE_WRITE = 2'd2,
        HQM_AW_RMWPIPE_RMW   = 2'd3
    } aw_rmwpipe_cmd_t;
endpackage

interface hqm_aw_rmw_req_fifo_issue_if
    import hqm_aw_rmwpipe_pkg::*;
#(
    parameter int DEPTHB2 = 3,
    parameter int WIDTH   = 32
);
    logic                 in_v;
    logic                 in_ready;
    aw_rmwpipe_cmd_t      in_rw;
    logic [DEPTHB2-1:0]   in_addr;
    logic [WIDTH-1:0]     in_wdata;
    logic                 p0_hold;
    logic                 p0_v_nxt;
    aw_rmwpipe_cmd_t      p0_rw_nxt;
    logic [DEPTHB2-1:0]   p0_addr_nxt;
    logic [WIDTH-1:0]     p0_write_data_nxt;

    modport master (
        output in_v, in_rw, in_addr, in_wdata, p0_hold,
        input  in_ready, p0_v_nxt, p0_rw_nxt, p0_addr_nxt, p0_write_data_nxt
    );

    modport slave (
        input  in_v, in_rw, in_addr, in_wdata, p0_hold,
        output in_ready, p0_v_nxt, p0_rw_nxt, p0_addr_nxt, p0_write_data_nxt
    );
endinterface

`default_nettype wire

// File: rtl/hqm_aw_rmw_req_fifo_issue.sv
// +----------------------------------------------------------------------------+
// | hqm_aw_rmw_req_fifo_issue : request FIFO feeding the RMW pipeline p0 stage |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module hqm_aw_rmw_req_fifo_issue
    import hqm_aw_rmwpipe_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int DEPTHB2    = $clog2(DEPTH),
    parameter int FIFOB2     = $clog2(FIFO_DEPTH)
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    hqm_aw_rmw_req_fifo_issue_if.slave      bus,
    output logic [FIFOB2:0]                 fifo_count,
    output logic [FIFOB2:0]                 fifo_hwm,
    output logic                            idle
);

    localparam logic [FIFOB2:0] c_full_count = (FIFOB2+1)'(FIFO_DEPTH);

    aw_rmwpipe_cmd_t        r_rw    [FIFO_DEPTH];
    logic [DEPTHB2-1:0]     r_addr  [FIFO_DEPTH];
    logic [WIDTH-1:0]       r_wdata [FIFO_DEPTH];

    logic [FIFOB2-1:0]      r_wp;
    logic [FIFOB2-1:0]      r_rp;
    logic [FIFOB2:0]        r_count;
    logic [FIFOB2:0]        r_hwm;

    logic                   w_in_ready;
    logic                   w_push;
    logic                   w_pop;
    logic [FIFOB2:0]        w_count_nxt;

    // Ready looks only at the registered count, so a full FIFO stays full
    // for one cycle even when the head is popping.
    assign w_in_ready  = ~rst & (r_count < c_full_count);
    assign w_push      = bus.in_v & w_in_ready;
    assign w_pop       = ~rst & (r_count != '0) & ~bus.p0_hold;
    assign w_count_nxt = r_count + (FIFOB2+1)'(w_push) - (FIFOB2+1)'(w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_hwm   <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            r_count <= w_count_nxt;
            if (w_count_nxt > r_hwm) r_hwm <= w_count_nxt;
        end
    end

    // Entry storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rw[r_wp]    <= bus.in_rw;
            r_addr[r_wp]  <= bus.in_addr;
            r_wdata[r_wp] <= bus.in_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (r_count <= c_full_count);
        end
    end

    assign bus.in_ready          = w_in_ready;
    assign bus.p0_v_nxt          = w_pop;
    assign bus.p0_rw_nxt         = r_rw[r_rp];
    assign bus.p0_addr_nxt       = r_addr[r_rp];
    assign bus.p0_write_data_nxt = r_wdata[r_rp];

    assign fifo_count = r_count;
    assign fifo_hwm   = r_hwm;
    assign idle       = (r_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_hqm_aw_rmw_req_fifo_issue.sv
// +----------------------------------------------------------------------------+
// | tb_hqm_aw_rmw_req_fifo_issue : directed bench for the RMW request FIFO     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hqm_aw_rmw_req_fifo_issue;
    import hqm_aw_rmwpipe_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] fifo_count;
    logic [2:0] fifo_hwm;
    logic       idle;
    int         n_vec = 0;
    int         n_err = 0;

    hqm_aw_rmw_req_fifo_issue_if #(.DEPTHB2(3), .WIDTH(32)) bus ();

    hqm_aw_rmw_req_fifo_issue #(
        .DEPTH      (8),
        .WIDTH      (32),
        .FIFO_DEPTH (4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fifo_count (fifo_count),
        .fifo_hwm   (fifo_hwm),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input aw_rmwpipe_cmd_t rw, input logic [2:0] addr,
                         input logic [31:0] data, input logic hold);
        bus.in_v     = v;
        bus.in_rw    = rw;
        bus.in_addr  = addr;
        bus.in_wdata = data;
        bus.p0_hold  = hold;
    endtask

    int idx;
    int exp_idx;

    initial begin
        drive(1'b0, HQM_AW_RMWPIPE_NOOP, 3'd0, 32'd0, 1'b0);

        // Reset behaviour
        cyc();
        cyc();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_p0_v", bus.p0_v_nxt, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_p0_v", bus.p0_v_nxt, 0);
        chk("post_rst_count", fifo_count, 0);
        chk("post_rst_hwm", fifo_hwm, 0);
        chk("post_rst_idle", idle, 1);

        // Single request, one-cycle latency
        drive(1'b1, HQM_AW_RMWPIPE_RMW, 3'd5, 32'hA5A5A5A5, 1'b0);
        #1;
        chk("single_no_fallthru", bus.p0_v_nxt, 0);
        cyc();
        drive(1'b0, HQM_AW_RMWPIPE_NOOP, 3'd0, 32'd0, 1'b0);
        #1;
        chk("single_v", bus.p0_v_nxt, 1);
        chk("single_rw", bus.p0_rw_nxt, HQM_AW_RMWPIPE_RMW);
        chk("single_addr", bus.p0_addr_nxt, 5);
        chk("single_data", bus.p0_write_data_nxt, 32'hA5A5A5A5);
        cyc();
        chk("single_v_once", bus.p0_v_nxt, 0);
        chk("single_idle", idle, 1);
        chk("single_hwm", fifo_hwm, 1);

        // Fill under hold
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, HQM_AW_RMWPIPE_WRITE, 3'(k), 32'(k), 1'b1);
            #1;
            chk("fill_ready", bus.in_ready, 1);
            chk("fill_no_issue", bus.p0_v_nxt, 0);
            cyc();
        end
        drive(1'b1, HQM_AW_RMWPIPE_WRITE, 3'd4, 32'd4, 1'b1);
        #1;
        chk("full_ready", bus.in_ready, 0);
        chk("full_count", fifo_count, 4);
        chk("full_hwm", fifo_hwm, 4);
        chk("full_head", bus.p0_addr_nxt, 0);
        cyc();
        chk("full_hold_count", fifo_count, 4);

        // Full plus simultaneous pop: push rejected this cycle
        bus.p0_hold = 1'b0;
        #1;
        chk("fpop_v", bus.p0_v_nxt, 1);
        chk("fpop_addr", bus.p0_addr_nxt, 0);
        chk("fpop_ready", bus.in_ready, 0);
        cyc();
        chk("fpop_count", fifo_count, 3);
        chk("fpop_ready_next", bus.in_ready, 1);
        chk("drain_addr1", bus.p0_addr_nxt, 1);
        cyc();
        drive(1'b1, HQM_AW_RMWPIPE_WRITE, 3'd5, 32'd5, 1'b0);
        #1;
        chk("drain_addr2", bus.p0_addr_nxt, 2);
        chk("drain_count2", fifo_count, 3);
        cyc();
        drive(1'b0, HQM_AW_RMWPIPE_NOOP, 3'd0, 32'd0, 1'b0);
        #1;
        chk("drain_addr3", bus.p0_addr_nxt, 3);
        cyc();
        chk("drain_addr4", bus.p0_addr_nxt, 4);
        chk("drain_v4", bus.p0_v_nxt, 1);
        cyc();
        chk("drain_addr5", bus.p0_addr_nxt, 5);
        chk("drain_v5", bus.p0_v_nxt, 1);
        cyc();
        chk("drain_idle", idle, 1);
        chk("drain_v_off", bus.p0_v_nxt, 0);
        chk("drain_hwm_sticky", fifo_hwm, 4);

        // Simultaneous push/pop at count 1
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, HQM_AW_RMWPIPE_READ, 3'(k), 32'(k), 1'b0);
            #1;
            if (k > 0) begin
                chk("ss_v", bus.p0_v_nxt, 1);
                chk("ss_addr", bus.p0_addr_nxt, k - 1);
                chk("ss_count", fifo_count, 1);
            end
            cyc();
        end
        drive(1'b0, HQM_AW_RMWPIPE_NOOP, 3'd0, 32'd0, 1'b0);
        #1;
        chk("ss_last_addr", bus.p0_addr_nxt, 5);
        cyc();
        chk("ss_idle", idle, 1);

        // Wrap and streaming with hold 1-on/2-off
        idx = 0;
        exp_idx = 0;
        for (int c = 0; c < 100 && exp_idx < 20; c++) begin
            drive(idx < 20, HQM_AW_RMWPIPE_WRITE, idx[2:0], 32'(idx), (c % 3) == 0);
            #1;
            if (bus.p0_hold) begin
                chk("stream_hold_quiet", bus.p0_v_nxt, 0);
            end else if (bus.p0_v_nxt) begin
                chk("stream_order", bus.p0_write_data_nxt, exp_idx);
                exp_idx++;
            end
            if (bus.in_v && bus.in_ready) idx++;
            cyc();
        end
        drive(1'b0, HQM_AW_RMWPIPE_NOOP, 3'd0, 32'd0, 1'b0);
        #1;
        chk("stream_issued", exp_idx, 20);
        chk("stream_pushed", idx, 20);
        chk("stream_idle", idle, 1);

        // Reset mid-operation with three buffered
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, HQM_AW_RMWPIPE_WRITE, 3'(k), 32'(k), 1'b1);
            cyc();
        end
        drive(1'b0, HQM_AW_RMWPIPE_NOOP, 3'd0, 32'd0, 1'b0);
        #1;
        chk("mid_count3", fifo_count, 3);
        rst = 1'b1;
        #1;
        chk("mid_rst_v", bus.p0_v_nxt, 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("mid_count", fifo_count, 0);
        chk("mid_hwm", fifo_hwm, 0);
        chk("mid_idle", idle, 1);
        chk("mid_v", bus.p0_v_nxt, 0);
        drive(1'b1, HQM_AW_RMWPIPE_READ, 3'd7, 32'h77, 1'b0);
        cyc();
        drive(1'b0, HQM_AW_RMWPIPE_NOOP, 3'd0, 32'd0, 1'b0);
        #1;
        chk("mid_new_v", bus.p0_v_nxt, 1);
        chk("mid_new_addr", bus.p0_addr_nxt, 7);
        chk("mid_new_rw", bus.p0_rw_nxt, HQM_AW_RMWPIPE_READ);
        cyc();
        chk("mid_no_stale", bus.p0_v_nxt, 0);
        chk("mid_final_idle", idle, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
